// File: rtl/ram_arbiter.sv
// Two-port round-robin front end for a single change-detect ram: turns the ram's
// response pin into a req/ack handshake, range-checks addresses, bounds each wait.
module ram_arbiter #(
  parameter int DEPTH       = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] ram_data,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  input  logic        ram_response,
  input  logic [31:0] ram_out,
  output logic        busy
);

  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic [CW-1:0] wait_cnt;

  logic          sel_valid;
  logic          sel;
  logic          sel_wr;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_range_err;

  // On a tie the port that was not served last wins; otherwise whoever asks.
  always_comb begin
    sel_valid     = p0_req | p1_req;
    sel           = (p0_req && p1_req) ? ~last_grant : p1_req;
    sel_wr        = sel ? p1_wr    : p0_wr;
    sel_addr      = sel ? p1_addr  : p0_addr;
    sel_wdata     = sel ? p1_wdata : p0_wdata;
    sel_range_err = (sel_addr >= 32'(DEPTH));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      p0_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p0_rdata   <= '0;
      p1_ack     <= 1'b0;
      p1_err     <= 1'b0;
      p1_rdata   <= '0;
      ram_data   <= '0;
      ram_addr   <= '0;
      ram_wr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            grant      <= sel;
            last_grant <= sel;
            if (sel_range_err) begin
              p0_ack <= ~sel;
              p1_ack <= sel;
              p0_err <= ~sel;
              p1_err <= sel;
              state  <= ACK;
            end else begin
              ram_addr <= sel_addr;
              ram_data <= sel_wdata;
              ram_wr   <= sel_wr;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // ram_wr drops on entry to ACK so the ram never repeats the write.
          if (ram_response) begin
            p0_ack <= ~grant;
            p1_ack <= grant;
            ram_wr <= 1'b0;
            state  <= ACK;
            if (!ram_wr) begin
              if (grant) p1_rdata <= ram_out;
              else       p0_rdata <= ram_out;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
              p0_ack <= ~grant;
              p1_ack <= grant;
              p0_err <= ~grant;
              p1_err <= grant;
              ram_wr <= 1'b0;
              state  <= ACK;
            end
          end
        end
        ACK: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          p0_err <= 1'b0;
          p1_err <= 1'b0;
          ram_wr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, reset/round-robin sequences and
// randomized two-port traffic checked against a transaction-level model.
module tb_ram_arbiter;
  localparam int DEPTH       = 32;
  localparam int TIMEOUT_CYC = 15;
  localparam int MAX_WAIT    = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        p0_req = 1'b0, p0_wr = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p1_req = 1'b0, p1_wr = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] ram_data, ram_addr;
  logic        ram_wr;
  logic        ram_response = 1'b0;
  logic [31:0] ram_out = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_response(ram_response), .ram_out(ram_out), .busy(busy)
  );

  // Change-detect ram: any input change drops response for a cycle, stable
  // inputs perform the access and raise response; ram_stuck withholds it.
  logic        ram_stuck = 1'b0;
  logic [64:0] ram_seen = '0;
  logic [31:0] ram_mem [DEPTH] = '{default: '0};

  always @(posedge clk) begin
    if ({ram_addr, ram_data, ram_wr} != ram_seen) begin
      ram_seen     <= {ram_addr, ram_data, ram_wr};
      ram_response <= 1'b0;
    end else if (ram_stuck) begin
      ram_response <= 1'b0;
    end else begin
      ram_response <= 1'b1;
      if (ram_wr) ram_mem[ram_addr[4:0]] <= ram_data;
      ram_out <= ram_mem[ram_addr[4:0]];
    end
  end

  // Transaction-level reference: memory contents, per-port read data, last
  // grant and the last inputs handed to the ram (write flag always ends at 0).
  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] raddr;
    logic [31:0] rdat;
  } exp_t;

  logic [31:0] ref_mem [DEPTH] = '{default: '0};
  logic [31:0] ref_rdata [2] = '{default: '0};
  logic        ref_last_grant = 1'b1;
  logic [31:0] ref_last_addr = '0;
  logic [31:0] ref_last_data = '0;

  function automatic exp_t predict(input int port, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] data, input logic stuck);
    exp_t e;
    ref_last_grant = (port == 1);
    if (addr >= 32'(DEPTH)) begin
      e.lat = 1;
      e.err = 1'b1;
    end else if (stuck) begin
      e.lat = TIMEOUT_CYC + 2;
      e.err = 1'b1;
      ref_last_addr = addr;
      ref_last_data = data;
    end else begin
      e.lat = (!wr && addr == ref_last_addr && data == ref_last_data) ? 3 : 4;
      e.err = 1'b0;
      if (wr) ref_mem[addr[4:0]] = data;
      else    ref_rdata[port] = ref_mem[addr[4:0]];
      ref_last_addr = addr;
      ref_last_data = data;
    end
    e.rdata = ref_rdata[port];
    e.raddr = ref_last_addr;
    e.rdat  = ref_last_data;
    return e;
  endfunction

  int          got_lat   [2];
  logic        got_err   [2];
  logic [31:0] got_rdata [2];
  logic        got_ramwr [2];
  logic        got_busy  [2];
  logic [31:0] got_raddr [2];
  logic [31:0] got_rdat  [2];
  int          spurious;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Raise the requested ports, then hold each req until its ack is seen.
  task automatic applyStimulus(input logic use0, input logic use1,
                               input logic wr0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic wr1, input logic [31:0] a1, input logic [31:0] d1);
    logic pend0, pend1;
    @(negedge clk);
    p0_req = use0; p0_wr = wr0; p0_addr = a0; p0_wdata = d0;
    p1_req = use1; p1_wr = wr1; p1_addr = a1; p1_wdata = d1;
    pend0 = use0;
    pend1 = use1;
    got_lat[0] = -1;
    got_lat[1] = -1;
    spurious = 0;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      if (!pend0 && !pend1) break;
      @(negedge clk);
      if (p0_ack && p1_ack) spurious++;
      if (p0_ack) begin
        if (pend0) begin
          got_lat[0] = c; got_err[0] = p0_err; got_rdata[0] = p0_rdata;
          got_ramwr[0] = ram_wr; got_busy[0] = busy;
          got_raddr[0] = ram_addr; got_rdat[0] = ram_data;
          pend0 = 1'b0;
          p0_req = 1'b0;
        end else spurious++;
      end
      if (p1_ack) begin
        if (pend1) begin
          got_lat[1] = c; got_err[1] = p1_err; got_rdata[1] = p1_rdata;
          got_ramwr[1] = ram_wr; got_busy[1] = busy;
          got_raddr[1] = ram_addr; got_rdat[1] = ram_data;
          pend1 = 1'b0;
          p1_req = 1'b0;
        end else spurious++;
      end
    end
  endtask

  task automatic checkPort(input string tag, input int p, input int lat, input exp_t e);
    checkOutput($sformatf("%s_p%0d_lat", tag, p), 32'(got_lat[p]), 32'(lat));
    checkOutput($sformatf("%s_p%0d_err", tag, p), 32'(got_err[p]), 32'(e.err));
    checkOutput($sformatf("%s_p%0d_rdata", tag, p), got_rdata[p], e.rdata);
    checkOutput($sformatf("%s_p%0d_ramwr", tag, p), 32'(got_ramwr[p]), 32'h0);
    checkOutput($sformatf("%s_p%0d_busy", tag, p), 32'(got_busy[p]), 32'h1);
    checkOutput($sformatf("%s_p%0d_ramaddr", tag, p), got_raddr[p], e.raddr);
    checkOutput($sformatf("%s_p%0d_ramdata", tag, p), got_rdat[p], e.rdat);
  endtask

  task automatic runTxn(input string tag, input logic use0, input logic use1,
                        input logic wr0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic wr1, input logic [31:0] a1, input logic [31:0] d1);
    exp_t e [2];
    int   lat [2];
    int   first;
    first = (use0 && use1) ? (ref_last_grant ? 0 : 1) : (use1 ? 1 : 0);
    if (first == 0) begin
      if (use0) e[0] = predict(0, wr0, a0, d0, 1'b0);
      if (use1) e[1] = predict(1, wr1, a1, d1, 1'b0);
      lat[0] = e[0].lat;
      lat[1] = use0 ? e[0].lat + 1 + e[1].lat : e[1].lat;
    end else begin
      e[1] = predict(1, wr1, a1, d1, 1'b0);
      if (use0) e[0] = predict(0, wr0, a0, d0, 1'b0);
      lat[1] = e[1].lat;
      lat[0] = e[1].lat + 1 + e[0].lat;
    end
    applyStimulus(use0, use1, wr0, a0, d0, wr1, a1, d1);
    if (use0) checkPort(tag, 0, lat[0], e[0]);
    if (use1) checkPort(tag, 1, lat[1], e[1]);
    checkOutput({tag, "_spurious_ack"}, 32'(spurious), 32'h0);
  endtask

  typedef struct {
    string       name;
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stuck;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [$];

  initial begin
    vec_t        v;
    exp_t        e;
    int          p;
    int          ack_cnt;
    logic        use0, use1, w0, w1;
    logic [31:0] a0, a1, d0, d1;

    vecs.push_back('{"wr_a5",     1'b0, 1'b1, 32'd5,        32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 4});
    vecs.push_back('{"rd_a5",     1'b1, 1'b0, 32'd5,        32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF, 4});
    vecs.push_back('{"rd_a32",    1'b1, 1'b0, 32'd32,       32'h00000000, 1'b0, 1'b1, 32'hDEADBEEF, 1});
    vecs.push_back('{"wr_a3",     1'b0, 1'b1, 32'd3,        32'h12345678, 1'b0, 1'b0, 32'h00000000, 4});
    vecs.push_back('{"rd_a3",     1'b0, 1'b0, 32'd3,        32'h00000000, 1'b0, 1'b0, 32'h12345678, 4});
    vecs.push_back('{"rd_a3_rep", 1'b0, 1'b0, 32'd3,        32'h00000000, 1'b0, 1'b0, 32'h12345678, 3});
    vecs.push_back('{"wr_a31",    1'b0, 1'b1, 32'd31,       32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678, 4});
    vecs.push_back('{"rd_a31",    1'b1, 1'b0, 32'd31,       32'h00000000, 1'b0, 1'b0, 32'hA5A5A5A5, 4});
    vecs.push_back('{"timeout",   1'b0, 1'b0, 32'd9,        32'h00000000, 1'b1, 1'b1, 32'h12345678, TIMEOUT_CYC + 2});
    vecs.push_back('{"rd_amax",   1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'hA5A5A5A5, 1});
    vecs.push_back('{"rd_a5_2",   1'b1, 1'b0, 32'd5,        32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF, 4});

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", 32'({p0_ack, p0_err, p1_ack, p1_err, ram_wr, busy}), 32'h0);
    checkOutput("reset_ram_addr", ram_addr, 32'h0);
    checkOutput("reset_ram_data", ram_data, 32'h0);
    checkOutput("reset_p0_rdata", p0_rdata, 32'h0);
    checkOutput("reset_p1_rdata", p1_rdata, 32'h0);
    rst_n = 1'b1;

    // Tie after reset goes to port 0; a lone p0 in between hands the next tie to p1.
    runTxn("rr_a", 1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 1'b0, 32'd2, 32'h0);
    checkOutput("rr_a_p0_first", 32'(got_lat[0] < got_lat[1]), 32'h1);
    runTxn("rr_b", 1'b1, 1'b0, 1'b0, 32'd1, 32'h0, 1'b0, 32'd0, 32'h0);
    runTxn("rr_c", 1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 1'b0, 32'd2, 32'h0);
    checkOutput("rr_c_p1_first", 32'(got_lat[1] < got_lat[0]), 32'h1);

    foreach (vecs[i]) begin
      v = vecs[i];
      p = v.port ? 1 : 0;
      ram_stuck = v.stuck;
      e = predict(p, v.wr, v.addr, v.wdata, v.stuck);
      applyStimulus(!v.port, v.port, v.wr, v.addr, v.wdata, v.wr, v.addr, v.wdata);
      ram_stuck = 1'b0;
      checkOutput({v.name, "_lat"}, 32'(got_lat[p]), 32'(v.exp_lat));
      checkOutput({v.name, "_err"}, 32'(got_err[p]), 32'(v.exp_err));
      checkOutput({v.name, "_rdata"}, got_rdata[p], v.exp_rdata);
      checkOutput({v.name, "_ramwr"}, 32'(got_ramwr[p]), 32'h0);
      checkOutput({v.name, "_ramaddr"}, got_raddr[p], e.raddr);
      checkOutput({v.name, "_ramdata"}, got_rdat[p], e.rdat);
      checkOutput({v.name, "_spurious_ack"}, 32'(spurious), 32'h0);
    end

    // Reset while the ram access is in WAIT: everything clears at once, no ack follows.
    @(negedge clk);
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 32'd7; p0_wdata = 32'h77;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_busy_before", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ctrl", 32'({p0_ack, p0_err, p1_ack, p1_err, ram_wr, busy}), 32'h0);
    checkOutput("midrst_ram_addr", ram_addr, 32'h0);
    checkOutput("midrst_ram_data", ram_data, 32'h0);
    checkOutput("midrst_p0_rdata", p0_rdata, 32'h0);
    checkOutput("midrst_p1_rdata", p1_rdata, 32'h0);
    p0_req = 1'b0;
    ack_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (p0_ack || p1_ack) ack_cnt++;
    end
    checkOutput("midrst_no_ack", 32'(ack_cnt), 32'h0);
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    ref_last_grant = 1'b1;
    ref_last_addr = '0;
    ref_last_data = '0;
    runTxn("post_rst", 1'b1, 1'b0, 1'b0, 32'd5, 32'h55, 1'b0, 32'd0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       begin use0 = 1'b1; use1 = 1'b0; end
        1:       begin use0 = 1'b0; use1 = 1'b1; end
        default: begin use0 = 1'b1; use1 = 1'b1; end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        w0 = 1'b0; a0 = ref_last_addr; d0 = ref_last_data;
      end else begin
        w0 = 1'($urandom_range(0, 1)); a0 = 32'($urandom_range(0, DEPTH + 7)); d0 = $urandom();
      end
      if ($urandom_range(0, 3) == 0) begin
        w1 = 1'b0; a1 = ref_last_addr; d1 = ref_last_data;
      end else begin
        w1 = 1'($urandom_range(0, 1)); a1 = 32'($urandom_range(0, DEPTH + 7)); d1 = $urandom();
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      runTxn($sformatf("rnd%0d", i), use0, use1, w0, a0, d0, w1, a1, d1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
